// File: rtl/asmd_pkg.sv
// rtl/asmd_pkg.sv - shared state encoding for the ASMD multiplier sequencer
package asmd_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SETTLE = 2'd2,
        BUSY   = 2'd3
    } state_t;

endpackage

// File: rtl/asmd_watchdog.sv
// rtl/asmd_watchdog.sv - clearable completion watchdog, flags expiry at TIMEOUT-1
module asmd_watchdog #(
    parameter int TIMEOUT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT - 1));

    // Count enabled cycles; hold at the expiry value so the flag cannot wrap away
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/asmd_mult_sequencer.sv
// rtl/asmd_mult_sequencer.sv - operand feeder and result holder for the ASMD shift-add multiplier
module asmd_mult_sequencer
    import asmd_pkg::*;
#(
    parameter int WORD_LENGTH = 4,
    parameter int TIMEOUT     = 4 * WORD_LENGTH + 4,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_LENGTH-1:0]   in_a,
    input  logic [WORD_LENGTH-1:0]   in_b,
    output logic                     mul_start,
    output logic [WORD_LENGTH-1:0]   mul_word0,
    output logic [WORD_LENGTH-1:0]   mul_word1,
    input  logic                     mul_ready,
    input  logic [2*WORD_LENGTH-1:0] mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WORD_LENGTH-1:0] out_product,
    output logic [CNT_W-1:0]         result_cnt,
    output logic                     err_timeout
);

    state_t state;
    logic   wd_expired;
    logic   capture;
    logic   fire;

    // A finished product is taken only when the output slot is empty or draining this cycle
    assign capture = (state == BUSY) && mul_ready && (!out_valid || out_ready);
    assign fire    = out_valid && out_ready;

    asmd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == SETTLE),
        .enable  (state == BUSY),
        .expired (wd_expired)
    );

    // Control FSM: accept a pair, pulse start, skip the stale-ready cycle, wait for done or abort
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            mul_start   <= 1'b0;
            mul_word0   <= '0;
            mul_word1   <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mul_word0 <= in_a;
                        mul_word1 <= in_b;
                        in_ready  <= 1'b0;
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    mul_start <= 1'b0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    // Multiplier may still show ready from before the start pulse
                    state <= BUSY;
                end
                BUSY: begin
                    if (capture) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (wd_expired) begin
                        err_timeout <= 1'b1;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One-entry result register and delivered-result counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            result_cnt  <= '0;
        end else begin
            if (capture) begin
                out_product <= mul_product;
                out_valid   <= 1'b1;
            end else if (fire) begin
                out_valid   <= 1'b0;
            end
            if (fire) begin
                result_cnt <= result_cnt + 1'b1;
            end
        end
    end

endmodule
